pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32I pipeline. It drives the enable (stall) and clear (flush) inputs of the F/D/E/M/W pipeline registers. It handles load-use hazards, taken branches/jumps resolved in Execute, and data-cache misses raised in Memory. On a miss it runs a miss/refill handshake toward the memory side and freezes the whole pipeline until the line is refilled. It also keeps miss-statistics counters.

---
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush controller for a 5-stage RV32I pipeline with a
//               data-cache miss/refill handshake and saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    rs1_d,
    input  logic [4:0]    rs2_d,
    input  logic [4:0]    rd_e,
    input  logic          mem_read_e,
    input  logic          pc_src_e,
    input  logic          cache_miss_m,
    input  logic          mem_ack,
    output logic          stall_f,
    output logic          stall_d,
    output logic          stall_e,
    output logic          stall_m,
    output logic          stall_w,
    output logic          flush_d,
    output logic          flush_e,
    output logic          mem_req,
    output logic          refill_we,
    output logic [CW-1:0] miss_count,
    output logic [CW-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_MAX = {CW{1'b1}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_miss_count;
    logic [CW-1:0] r_stall_cycles;

    logic          w_running;
    logic          w_miss_start;
    logic          w_freeze;
    logic          w_lw_stall;

    assign w_running    = (r_state == ST_RUN);
    assign w_miss_start = w_running & cache_miss_m;
    assign w_freeze     = ~w_running | cache_miss_m;

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign w_lw_stall = mem_read_e & (rd_e != 5'd0) &
                        ((rd_e == rs1_d) | (rd_e == rs2_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (cache_miss_m) begin
                    w_state_nxt = ST_MISS;
                end
            end
            ST_MISS: begin
                if (mem_ack) begin
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Priority: cache freeze, then branch redirect, then load-use bubble.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        stall_w = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (w_freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign mem_req   = (r_state == ST_MISS);
    assign refill_we = (r_state == ST_REFILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_count   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_miss_start && (r_miss_count != C_MAX)) begin
                r_miss_count <= r_miss_count + C_ONE;
            end
            if (!w_running && (r_stall_cycles != C_MAX)) begin
                r_stall_cycles <= r_stall_cycles + C_ONE;
            end
        end
    end

    assign miss_count   = r_miss_count;
    assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Scoreboard bench: directed scenarios then random traffic
//               checked against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic [8:0]    ctl;
        logic [CW-1:0] mc;
        logic [CW-1:0] sc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_d, rs2_d, rd_e;
    logic          mem_read_e, pc_src_e, cache_miss_m, mem_ack;
    logic          stall_f, stall_d, stall_e, stall_m, stall_w;
    logic          flush_d, flush_e, mem_req, refill_we;
    logic [CW-1:0] miss_count, stall_cycles;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    // Model: 0 = running, 1 = waiting for the refill line, 2 = writing it.
    int m_phase;
    int m_misses;
    int m_stalls;

    pipeline_hazard_ctrl #(.CW(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
        .mem_read_e(mem_read_e), .pc_src_e(pc_src_e),
        .cache_miss_m(cache_miss_m), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .stall_m(stall_m), .stall_w(stall_w),
        .flush_d(flush_d), .flush_e(flush_e),
        .mem_req(mem_req), .refill_we(refill_we),
        .miss_count(miss_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic int sat_inc(int v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    // Called at posedge+1: drive inputs, predict this cycle, then advance the model.
    task automatic step(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] rd, input logic mr, input logic pc,
                        input logic miss, input logic ack);
        exp_t e;
        logic hz, frz;
        rst = r; rs1_d = s1; rs2_d = s2; rd_e = rd;
        mem_read_e = mr; pc_src_e = pc; cache_miss_m = miss; mem_ack = ack;
        if (r) begin
            m_phase = 0; m_misses = 0; m_stalls = 0;
        end
        frz = (m_phase != 0) || miss;
        hz  = mr && (rd != 5'd0) && (rd == s1 || rd == s2);
        if (frz)      e.ctl = 9'b11111_00_00;
        else if (pc)  e.ctl = 9'b00000_11_00;
        else if (hz)  e.ctl = 9'b11000_01_00;
        else          e.ctl = 9'b00000_00_00;
        e.ctl[1] = (m_phase == 1);
        e.ctl[0] = (m_phase == 2);
        e.mc = m_misses[CW-1:0];
        e.sc = m_stalls[CW-1:0];
        q.push_back(e);
        @(posedge clk);
        if (!r) begin
            if (m_phase != 0) m_stalls = sat_inc(m_stalls);
            if (m_phase == 0 && miss) begin
                m_phase = 1; m_misses = sat_inc(m_misses);
            end else if (m_phase == 1 && ack) m_phase = 2;
            else if (m_phase == 2) m_phase = 0;
        end
        #1;
    endtask

    task automatic idle(input logic miss, input logic ack);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, miss, ack);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e,
                 mem_req, refill_we} !== e.ctl) begin
                miscompares++;
                $display("FAIL ctl t=%0t got=%b exp=%b (sF sD sE sM sW fD fE req we)",
                         $time, {stall_f, stall_d, stall_e, stall_m, stall_w,
                         flush_d, flush_e, mem_req, refill_we}, e.ctl);
            end
            vectors++;
            if (miss_count !== e.mc) begin
                miscompares++;
                $display("FAIL miss_count t=%0t got=%0d exp=%0d", $time, miss_count, e.mc);
            end
            vectors++;
            if (stall_cycles !== e.sc) begin
                miscompares++;
                $display("FAIL stall_cycles t=%0t got=%0d exp=%0d", $time, stall_cycles, e.sc);
            end
        end
    end

    initial begin
        m_phase = 0; m_misses = 0; m_stalls = 0;
        rst = 1'b1; rs1_d = '0; rs2_d = '0; rd_e = '0;
        mem_read_e = 1'b0; pc_src_e = 1'b0; cache_miss_m = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load-use hit, then the same load targeting x0.
        step(1'b0, 5'd7, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Branch alone, then branch colliding with a load-use hazard.
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // Miss with k=3, hazard inputs active but ignored.
        step(1'b0, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        // Back-to-back: miss held across the return to RUN.
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // Reset while waiting for the refill.
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        // Long miss: stall counter must stick at its maximum.
        idle(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
        end
        #6;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d exp=0 pending entries", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
